uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning number of data bits per frame.
REQ-002 SHALL have port clk  input  1  receiver oversampling clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RX_IN  input  1  serial line, idle high, asynchronous to clk.
REQ-005 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-006 SHALL have port PAR_TYP  input  1  0 = even (parity bit = XOR of data), 1 = odd (XNOR).
REQ-007 SHALL have port Prescale  input  6  clk cycles per bit; legal values 8, 16, 32.
REQ-008 SHALL have port P_DATA  output  DATAWIDTH  received data word.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse, P_DATA good.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse, parity mismatch.
REQ-011 SHALL have port stp_err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-012 SHALL pass RX_IN through a 2-flop synchronizer (reset value 1); all logic uses the synchronized bit rx_s.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL keep edge_cnt (0..Prescale-1, wraps to 0 at Prescale-1) and bit_cnt (0..DATAWIDTH-1); both cleared in IDLE.
REQ-015 IDLE -> START when rx_s = 0; PAR_EN, PAR_TYP and Prescale SHALL be latched on this transition and held for the frame.
REQ-016 Each bit SHALL be decided by majority vote of rx_s at edge_cnt = Prescale/2-1, Prescale/2, Prescale/2+1; decision valid at edge_cnt = Prescale/2+1.
REQ-017 START: decided 1 (glitch) -> IDLE with no output pulse; decided 0 -> DATA at edge_cnt wrap.
REQ-018 DATA: bits shifted in LSB first; after bit DATAWIDTH-1 wraps -> PARITY if latched PAR_EN = 1, else STOP.
REQ-019 PARITY: decided bit compared with XOR of received data (inverted when latched PAR_TYP = 1); -> STOP at edge_cnt wrap.
REQ-020 STOP: at stop decision point FSM SHALL return to IDLE immediately (half-bit early) so back-to-back frames are captured.
REQ-021 On the cycle after the stop decision: stop = 0 -> stp_err = 1; parity mismatch -> par_err = 1; both may assert together.
REQ-022 data_valid SHALL pulse on that same cycle only when neither error applies; P_DATA updates on that cycle and holds until next valid frame.
REQ-023 On an errored frame P_DATA SHALL keep its previous value.
REQ-024 Prescale or PAR_EN/PAR_TYP changes mid-frame SHALL NOT affect the current frame.
REQ-025 Latency: data_valid asserts 2 (sync) + frame decision point + 1 clk after the start-bit falling edge on RX_IN.
REQ-026 Break (rx_s low through stop) SHALL yield stp_err, then a new START from IDLE; a glitch decided 1 SHALL return to IDLE.

Reset
REQ-027 On rst = 0: FSM = IDLE, counters = 0, synchronizer = 1, P_DATA = 0, data_valid = par_err = stp_err = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no output pulse; first frame after release SHALL be received correctly.

Verification
REQ-029 Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0, stop 1 -> P_DATA=0xA5, data_valid one cycle, no errors.
REQ-030 Prescale=16, PAR_TYP=1, 0xA5 with parity 0 -> par_err one cycle, data_valid 0, P_DATA unchanged.
REQ-031 Prescale=32, PAR_EN=0, 0x3C, stop bit driven 0 -> stp_err one cycle, data_valid 0.
REQ-032 Prescale=8, 2-clk low pulse on idle line -> FSM back to IDLE, no output pulses; next frame 0x5A received OK.
REQ-033 Two back-to-back frames 0x01, 0xFE (no idle gap) -> two data_valid pulses with P_DATA 0x01 then 0xFE.
REQ-034 rst asserted during DATA bit 4 of frame 0xFF -> all outputs 0; following frame 0x81 -> P_DATA=0x81, data_valid.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver core: oversampled, majority-voted bit decisions, optional parity.
// Returns to IDLE at the stop-bit decision point so back-to-back frames are caught.
module uart_rx_core #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX_IN,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic [5:0]           Prescale,
    output logic [DATAWIDTH-1:0] P_DATA,
    output logic                 data_valid,
    output logic                 par_err,
    output logic                 stp_err
);

    localparam int BW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // Handshake: data_valid, par_err and stp_err are single-cycle pulses with no
    // back-pressure; P_DATA is meaningful whenever data_valid is high and holds after.

    state_t                 state_q, state_d;
    logic                   rx_meta, rx_s;
    logic                   par_en_q, par_typ_q;
    logic [5:0]             prescale_q;
    logic [5:0]             edge_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [1:0]             samp;
    logic [DATAWIDTH-1:0]   shift_q;
    logic                   par_bit_q;

    logic [5:0]             half;
    logic                   wrap, decide_pt, voted, last_bit, stop_bad, par_bad;

    always_comb begin
        half      = {1'b0, prescale_q[5:1]};
        wrap      = (edge_cnt == prescale_q - 6'd1);
        decide_pt = (edge_cnt == half + 6'd1);
        voted     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
        last_bit  = (bit_cnt == BW'(DATAWIDTH - 1));
        stop_bad  = ~voted;
        par_bad   = par_en_q & (par_bit_q != ((^shift_q) ^ par_typ_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!rx_s) state_d = START;
            START: begin
                // A start bit that votes high was a glitch on the idle line.
                if (decide_pt && voted) state_d = IDLE;
                else if (wrap)          state_d = DATA;
            end
            DATA:   if (wrap && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (wrap) state_d = STOP;
            STOP:   if (decide_pt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            prescale_q <= 6'd0;
            edge_cnt   <= 6'd0;
            bit_cnt    <= '0;
            samp       <= 2'b11;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            rx_meta    <= RX_IN;
            rx_s       <= rx_meta;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state_q == IDLE) begin
                edge_cnt <= 6'd0;
                bit_cnt  <= '0;
                // Frame configuration is frozen at the start edge.
                if (!rx_s) begin
                    par_en_q   <= PAR_EN;
                    par_typ_q  <= PAR_TYP;
                    prescale_q <= Prescale;
                end
            end else begin
                edge_cnt <= wrap ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) samp[0] <= rx_s;
                if (edge_cnt == half)        samp[1] <= rx_s;
                if (state_q == DATA && decide_pt)
                    shift_q <= {voted, shift_q[DATAWIDTH-1:1]};
                if (state_q == DATA && wrap)
                    bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
                if (state_q == PARITY && decide_pt)
                    par_bit_q <= voted;
                if (state_q == STOP && decide_pt) begin
                    stp_err <= stop_bad;
                    par_err <= par_bad;
                    if (!stop_bad && !par_bad) begin
                        data_valid <= 1'b1;
                        P_DATA     <= shift_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: vector table of whole frames plus corner sequences.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;

    int checks = 0;
    int errors = 0;
    int n_val = 0;
    int n_par = 0;
    int n_stp = 0;
    logic [7:0] exp_q[$];

    uart_rx_core #(.DATAWIDTH(8)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ps;
        logic       pe;
        logic       pt;
        logic [7:0] d;
        logic       pbit;
        logic       sbit;
        int         e_val;
        int         e_par;
        int         e_stp;
        logic [7:0] e_pdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (data_valid) begin
            n_val++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected none", P_DATA);
            end else begin
                check("sb_pdata", 32'(P_DATA), 32'(exp_q.pop_front()));
            end
        end
        if (par_err) n_par++;
        if (stp_err) n_stp++;
    end

    task automatic send_frame(input int ps, input logic [7:0] d, input logic pe,
                              input logic pbit, input logic sbit);
        RX_IN = 1'b0;
        repeat (ps) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (ps) @(negedge clk);
        end
        if (pe) begin
            RX_IN = pbit;
            repeat (ps) @(negedge clk);
        end
        RX_IN = sbit;
        repeat (ps) @(negedge clk);
        RX_IN = 1'b1;
    endtask

    task automatic clear_counts();
        n_val = 0;
        n_par = 0;
        n_stp = 0;
    endtask

    initial begin
        //         ps  pe    pt    data   pbit  sbit  val par stp pdata
        vecs[0] = '{8,  1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[1] = '{16, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 0, 1, 0, 8'hA5};
        vecs[2] = '{32, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
        vecs[3] = '{16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1, 0, 0, 8'h00};
        vecs[4] = '{8,  1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 0, 1, 1, 8'h00};
        vecs[5] = '{32, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1, 0, 0, 8'hFF};

        repeat (3) @(negedge clk);
        check("rst_pdata", 32'(P_DATA), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_par", 32'(par_err), 0);
        check("rst_stp", 32'(stp_err), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            Prescale = 6'(vecs[v].ps);
            PAR_EN   = vecs[v].pe;
            PAR_TYP  = vecs[v].pt;
            repeat (2 * vecs[v].ps) @(negedge clk);
            clear_counts();
            if (vecs[v].e_val != 0) exp_q.push_back(vecs[v].d);
            send_frame(vecs[v].ps, vecs[v].d, vecs[v].pe, vecs[v].pbit, vecs[v].sbit);
            repeat (3 * vecs[v].ps) @(negedge clk);
            check($sformatf("v%0d_valid", v), 32'(n_val), 32'(vecs[v].e_val));
            check($sformatf("v%0d_par", v), 32'(n_par), 32'(vecs[v].e_par));
            check($sformatf("v%0d_stp", v), 32'(n_stp), 32'(vecs[v].e_stp));
            check($sformatf("v%0d_pdata", v), 32'(P_DATA), 32'(vecs[v].e_pdata));
        end

        // Two-clock low glitch on an idle line, then a clean frame.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (16) @(negedge clk);
        clear_counts();
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_idle", 32'(dut.state_q), 0);
        check("glitch_pulses", 32'(n_val + n_par + n_stp), 0);
        exp_q.push_back(8'h5A);
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (24) @(negedge clk);
        check("after_glitch_valid", 32'(n_val), 1);
        check("after_glitch_pdata", 32'(P_DATA), 32'h5A);

        // Back-to-back frames with no idle gap between stop and next start.
        Prescale = 6'd16;
        repeat (32) @(negedge clk);
        clear_counts();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
        send_frame(16, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(16, 8'hFE, 1'b0, 1'b0, 1'b1);
        repeat (48) @(negedge clk);
        check("b2b_valid", 32'(n_val), 2);
        check("b2b_pdata", 32'(P_DATA), 32'hFE);
        check("b2b_errs", 32'(n_par + n_stp), 0);

        // Configuration inputs change mid-frame; the frame keeps its latched setup.
        Prescale = 6'd16;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        repeat (32) @(negedge clk);
        clear_counts();
        exp_q.push_back(8'h3C);
        fork
            send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1);
            begin
                repeat (40) @(negedge clk);
                Prescale = 6'd8;
                PAR_EN   = 1'b0;
                PAR_TYP  = 1'b1;
            end
        join
        repeat (48) @(negedge clk);
        check("cfg_hold_valid", 32'(n_val), 1);
        check("cfg_hold_errs", 32'(n_par + n_stp), 0);
        check("cfg_hold_pdata", 32'(P_DATA), 32'h3C);

        // Reset during data bit 4 of 0xFF, then a clean 0x81.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (16) @(negedge clk);
        clear_counts();
        fork
            send_frame(8, 8'hFF, 1'b0, 1'b0, 1'b1);
            begin
                repeat (5 * 8 + 4) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("midrst_pdata", 32'(P_DATA), 0);
                check("midrst_pulses", 32'({data_valid, par_err, stp_err}), 0);
                check("midrst_state", 32'(dut.state_q), 0);
                rst = 1'b1;
            end
        join
        repeat (24) @(negedge clk);
        check("midrst_no_pulse", 32'(n_val + n_par + n_stp), 0);
        exp_q.push_back(8'h81);
        send_frame(8, 8'h81, 1'b0, 1'b0, 1'b1);
        repeat (24) @(negedge clk);
        check("post_rst_valid", 32'(n_val), 1);
        check("post_rst_pdata", 32'(P_DATA), 32'h81);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
